dmem_access_arbiter: RTL

- Sequences and shares the single-port byte-addressed data memory between two requesters: the pipeline MEM stage (CPU) and a DMA/loader port.
- Arbitrates, drives the memory's address, write-data, write and read strobes for a fixed number of cycles, and registers the read word.
- Returns a one-cycle done pulse to the granted requester and stalls the pipeline while a CPU access is pending.
- Rejects misaligned or out-of-range word accesses without touching memory.

---
 rtl/dmem_access_arbiter_if.sv | 51 +++++
 rtl/dmem_access_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_access_arbiter_if.sv
// Bundles the CPU, DMA and data-memory signals of the data-memory access arbiter.
// master = requesters plus memory (environment side), slave = the arbiter itself.
interface dmem_access_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_done;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  logic              addr_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_done,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata,
    input  addr_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_done,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata,
    output addr_err
  );

endinterface

// File: rtl/dmem_access_arbiter.sv
// Shares a single-port data memory between the CPU MEM stage and a DMA port.
// Optional macro DMA_FAIRNESS_EN: grant DMA after STARVE_LIMIT CPU grants while it waits.
module dmem_access_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_BYTES    = 40,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 reset,
  dmem_access_arbiter_if.slave bus
);

  localparam int                WAIT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

  if (WAIT_CYCLES < 1 || STARVE_LIMIT < 1) begin : g_param_check
    $error("dmem_access_arbiter: WAIT_CYCLES and STARVE_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  state_t              state;
  owner_t              owner;
  logic                we_q;
  logic [WAIT_W-1:0]   wait_cnt;

  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_write_q;
  logic                mem_read_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   dma_rdata_q;
  logic                cpu_done_q;
  logic                dma_done_q;
  logic                addr_err_q;

  logic                any_req;
  logic                grant_dma;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                addr_bad;

`ifdef DMA_FAIRNESS_EN
  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  logic [STARVE_W-1:0]            starve_cnt;
`endif

  always_comb begin
    any_req = bus.cpu_req | bus.dma_req;
`ifdef DMA_FAIRNESS_EN
    grant_dma = bus.dma_req & (~bus.cpu_req | (starve_cnt >= STARVE_MAX));
`else
    grant_dma = bus.dma_req & ~bus.cpu_req;
`endif
    sel_we    = grant_dma ? bus.dma_we    : bus.cpu_we;
    sel_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
    sel_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
    // Widened by one bit so addr+3 cannot wrap past the top of the address space.
    addr_bad  = (sel_addr[1:0] != 2'b00) ||
                (({1'b0, sel_addr} + (ADDR_W + 1)'(3)) >= ADDR_LIMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= OWN_CPU;
      we_q        <= 1'b0;
      wait_cnt    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      addr_err_q  <= 1'b0;
`ifdef DMA_FAIRNESS_EN
      starve_cnt  <= '0;
`endif
    end else begin
      cpu_done_q <= 1'b0;
      dma_done_q <= 1'b0;
      addr_err_q <= 1'b0;

      case (state)
        IDLE: begin
`ifdef DMA_FAIRNESS_EN
          if (!bus.dma_req || grant_dma) begin
            starve_cnt <= '0;
          end else if (bus.cpu_req && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
          end
`endif
          if (any_req) begin
            owner       <= grant_dma ? OWN_DMA : OWN_CPU;
            we_q        <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            wait_cnt    <= '0;
            if (addr_bad) begin
              // Rejected accesses skip ACCESS entirely; done/addr_err are raised here
              // so they appear in the DONE cycle, one cycle after the grant.
              state      <= DONE;
              addr_err_q <= 1'b1;
              if (grant_dma) begin
                dma_done_q  <= 1'b1;
                dma_rdata_q <= '0;
              end else begin
                cpu_done_q  <= 1'b1;
                cpu_rdata_q <= '0;
              end
            end else begin
              state       <= ACCESS;
              mem_write_q <= sel_we;
              mem_read_q  <= ~sel_we;
            end
          end
        end

        ACCESS: begin
          if (wait_cnt == WAIT_LAST) begin
            state       <= DONE;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            if (owner == OWN_DMA) begin
              dma_done_q <= 1'b1;
              if (!we_q) dma_rdata_q <= bus.mem_rdata;
            end else begin
              cpu_done_q <= 1'b1;
              if (!we_q) cpu_rdata_q <= bus.mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state       <= IDLE;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.dma_done  = dma_done_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_done_q;

endmodule
